// File: rtl/lcd_sequencer.sv
// rtl/lcd_sequencer.sv - HD44780 4-bit power-up/init and byte-write sequencer driving lcd_transfer
module lcd_sequencer #(
    parameter int unsigned POWERUP_CYCLES = 750000,
    parameter int unsigned T_4MS          = 205000,
    parameter int unsigned T_100US        = 5000,
    parameter int unsigned T_CMD          = 2000,
    parameter int unsigned T_CLR          = 82000,
    parameter int unsigned T_NIB          = 50
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        wr_valid,
    input  logic        wr_rs,
    input  logic [7:0]  wr_data,
    output logic        wr_ready,
    output logic        init_done,
    output logic        sendCommand,
    output logic [4:0]  command,
    output logic [20:0] commandDelay,
    input  logic        commandDone
);

    typedef enum logic [2:0] {
        PWR_WAIT, INIT_SEND, INIT_WAIT, IDLE, SEND_HI, WAIT_HI, SEND_LO, WAIT_LO
    } state_t;

    localparam logic [20:0] PWR_LAST = 21'(POWERUP_CYCLES - 1);
    localparam logic [20:0] D_4MS    = 21'(T_4MS);
    localparam logic [20:0] D_100US  = 21'(T_100US);
    localparam logic [20:0] D_CMD    = 21'(T_CMD);
    localparam logic [20:0] D_CLR    = 21'(T_CLR);
    localparam logic [20:0] D_NIB    = 21'(T_NIB);
    localparam logic [3:0]  INIT_LAST = 4'd11;

    state_t      state_q, state_d;
    logic [20:0] pwr_cnt_q, pwr_cnt_d;
    logic [3:0]  init_idx_q, init_idx_d;
    logic        byte_rs_q, byte_rs_d;
    logic [7:0]  byte_data_q, byte_data_d;
    logic        send_q, send_d;
    logic [4:0]  cmd_q, cmd_d;
    logic [20:0] delay_q, delay_d;
    logic        init_done_q, init_done_d;

    logic [3:0]  rom_nib;
    logic [20:0] rom_dly;
    logic        lo_is_clear;

    always_comb begin
        rom_nib = 4'h0;
        rom_dly = D_CMD;
        case (init_idx_q)
            4'd0:    begin rom_nib = 4'h3; rom_dly = D_4MS;   end
            4'd1:    begin rom_nib = 4'h3; rom_dly = D_100US; end
            4'd2:    begin rom_nib = 4'h3; rom_dly = D_CMD;   end
            4'd3:    begin rom_nib = 4'h2; rom_dly = D_CMD;   end
            4'd4:    begin rom_nib = 4'h2; rom_dly = D_NIB;   end
            4'd5:    begin rom_nib = 4'h8; rom_dly = D_CMD;   end
            4'd6:    begin rom_nib = 4'h0; rom_dly = D_NIB;   end
            4'd7:    begin rom_nib = 4'hC; rom_dly = D_CMD;   end
            4'd8:    begin rom_nib = 4'h0; rom_dly = D_NIB;   end
            4'd9:    begin rom_nib = 4'h1; rom_dly = D_CLR;   end
            4'd10:   begin rom_nib = 4'h0; rom_dly = D_NIB;   end
            4'd11:   begin rom_nib = 4'h6; rom_dly = D_CMD;   end
            default: begin rom_nib = 4'h0; rom_dly = D_CMD;   end
        endcase
    end

    // Clear (0x01) and return-home (0x02/0x03) instructions need the long delay
    assign lo_is_clear = !byte_rs_q && (byte_data_q[7:2] == 6'd0) && (byte_data_q[1:0] != 2'd0);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= PWR_WAIT;
            pwr_cnt_q   <= '0;
            init_idx_q  <= '0;
            byte_rs_q   <= 1'b0;
            byte_data_q <= '0;
            send_q      <= 1'b0;
            cmd_q       <= '0;
            delay_q     <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pwr_cnt_q   <= pwr_cnt_d;
            init_idx_q  <= init_idx_d;
            byte_rs_q   <= byte_rs_d;
            byte_data_q <= byte_data_d;
            send_q      <= send_d;
            cmd_q       <= cmd_d;
            delay_q     <= delay_d;
            init_done_q <= init_done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pwr_cnt_d   = pwr_cnt_q;
        init_idx_d  = init_idx_q;
        byte_rs_d   = byte_rs_q;
        byte_data_d = byte_data_q;
        case (state_q)
            PWR_WAIT: begin
                if (pwr_cnt_q == PWR_LAST) begin
                    state_d    = INIT_SEND;
                    init_idx_d = 4'd0;
                end else begin
                    pwr_cnt_d = pwr_cnt_q + 21'd1;
                end
            end
            INIT_SEND: state_d = INIT_WAIT;
            INIT_WAIT: begin
                if (commandDone) begin
                    if (init_idx_q == INIT_LAST) begin
                        state_d = IDLE;
                    end else begin
                        init_idx_d = init_idx_q + 4'd1;
                        state_d    = INIT_SEND;
                    end
                end
            end
            IDLE: begin
                if (wr_valid) begin
                    byte_rs_d   = wr_rs;
                    byte_data_d = wr_data;
                    state_d     = SEND_HI;
                end
            end
            SEND_HI: state_d = WAIT_HI;
            WAIT_HI: if (commandDone) state_d = SEND_LO;
            SEND_LO: state_d = WAIT_LO;
            WAIT_LO: if (commandDone) state_d = IDLE;
            default: state_d = PWR_WAIT;
        endcase
    end

    always_comb begin
        send_d      = 1'b0;
        cmd_d       = cmd_q;
        delay_d     = delay_q;
        init_done_d = init_done_q;
        wr_ready    = (state_q == IDLE);
        case (state_q)
            INIT_SEND: begin
                send_d  = 1'b1;
                cmd_d   = {1'b0, rom_nib};
                delay_d = rom_dly;
            end
            INIT_WAIT: if (commandDone && init_idx_q == INIT_LAST) init_done_d = 1'b1;
            SEND_HI: begin
                send_d  = 1'b1;
                cmd_d   = {byte_rs_q, byte_data_q[7:4]};
                delay_d = D_NIB;
            end
            SEND_LO: begin
                send_d  = 1'b1;
                cmd_d   = {byte_rs_q, byte_data_q[3:0]};
                delay_d = lo_is_clear ? D_CLR : D_CMD;
            end
            default: ;
        endcase
    end

    assign sendCommand  = send_q;
    assign command      = cmd_q;
    assign commandDelay = delay_q;
    assign init_done    = init_done_q;

endmodule

// File: doc/lcd_sequencer.md
# lcd_sequencer

Controller that sequences the 4-bit LCD nibble transfer engine (`lcd_transfer`). After reset it waits out the HD44780 power-up time, then issues the 4-bit initialisation nibble sequence. After that it accepts byte writes (instruction or data) from a host through a valid/ready handshake and splits each byte into two nibble transfers, choosing the post-transfer delay for each one. It sits between the application logic and `lcd_transfer` and is the only driver of that engine's command port.

## Interface
Parameters (all in CLK cycles, each 1..2^21-1):
- POWERUP_CYCLES, 750000: wait after reset release before the first nibble (15 ms at 50 MHz).
- T_4MS, 205000: delay after init nibble 0.
- T_100US, 5000: delay after init nibble 1.
- T_CMD, 2000: standard instruction/data delay (40 us).
- T_CLR, 82000: delay after clear/home low nibble (1.64 ms).
- T_NIB, 50: delay after any high nibble (1 us).

Ports:
- CLK, input, 1: single clock.
- RST, input, 1: asynchronous, active-high reset.
- wr_valid, input, 1: host byte-write request.
- wr_rs, input, 1: 0 = instruction, 1 = data.
- wr_data, input, 8: byte to write.
- wr_ready, output, 1: high only in IDLE.
- init_done, output, 1: level; high once initialisation has completed.
- sendCommand, output, 1: one-cycle start pulse to `lcd_transfer`.
- command, output, 5: {rs, nibble} to `lcd_transfer`.
- commandDelay, output, 21: post-transfer delay to `lcd_transfer`.
- commandDone, input, 1: one-cycle completion pulse from `lcd_transfer`.

## Operation
- States: PWR_WAIT, INIT_SEND, INIT_WAIT, IDLE, SEND_HI, WAIT_HI, SEND_LO, WAIT_LO.
- PWR_WAIT: a 21-bit counter runs from 0. When it reaches POWERUP_CYCLES-1, the FSM goes to INIT_SEND with init index = 0.
- Init ROM. Entries are index: nibble/delay, all with rs=0:
  - 0: 3/T_4MS
  - 1: 3/T_100US
  - 2: 3/T_CMD
  - 3: 2/T_CMD
  - 4: 2/T_NIB
  - 5: 8/T_CMD
  - 6: 0/T_NIB
  - 7: C/T_CMD
  - 8: 0/T_NIB
  - 9: 1/T_CLR
  - 10: 0/T_NIB
  - 11: 6/T_CMD
- INIT_SEND: drive command/commandDelay from the ROM, pulse sendCommand, then go to INIT_WAIT.
- INIT_WAIT: on commandDone, if index = 11, set init_done and go to IDLE. Otherwise increment index and go to INIT_SEND.
- IDLE: wr_ready=1. On wr_valid & wr_ready, latch wr_rs and wr_data, then go to SEND_HI.
- SEND_HI: command = {rs, data[7:4]}, commandDelay = T_NIB. Pulse sendCommand, then go to WAIT_HI.
- WAIT_HI: on commandDone, go to SEND_LO.
- SEND_LO: command = {rs, data[3:0]}. commandDelay = T_CLR if rs=0 and data ∈ {0x01, 0x02, 0x03}; otherwise T_CMD. Pulse sendCommand, then go to WAIT_LO.
- WAIT_LO: on commandDone, go to IDLE.
- commandDone is ignored in every state except INIT_WAIT, WAIT_HI and WAIT_LO. This also covers a stale pulse from a transfer that was in flight when reset was applied.
- command and commandDelay are registered. They hold their value from the sendCommand cycle until the matching commandDone.
- wr_data and wr_rs are ignored while wr_ready=0. There is no queueing.

## Timing
- Reset values: sendCommand=0, command=0, commandDelay=0, wr_ready=0, init_done=0, state=PWR_WAIT, counters=0.
- RST asserted mid-transfer or mid-init: all outputs return immediately to their reset values. The power-up wait restarts when RST is released.
- First sendCommand occurs in cycle POWERUP_CYCLES+1 after RST deasserts (counter compare takes 1 cycle, then INIT_SEND takes 1 cycle).
- sendCommand is exactly 1 cycle wide and never high in two consecutive cycles.
- Handshake accepted at edge N: wr_ready=0 from N+1, sendCommand (high nibble) at N+1.
- commandDone at edge M in WAIT_HI: low-nibble sendCommand at M+1.
- commandDone at edge M in WAIT_LO: wr_ready=1 at M+1.
- commandDone on the last init entry at edge M: init_done=1 and wr_ready=1 at M+1.
- A commandDone that coincides with the cycle of a sendCommand is impossible by construction (WAIT states only).

## Test plan
- Init sequence, with a behavioural `lcd_transfer` model using POWERUP_CYCLES=20, T_NIB=2, T_CMD=5, T_CLR=9, T_4MS=7, T_100US=6. Required: 12 sendCommand pulses; commands 03,03,03,02,02,08,00,0C,00,01,00,06; delays 7,6,5,5,2,5,2,5,2,9,2,5; first pulse at cycle 21; init_done rises the cycle after the 12th commandDone.
- Data write rs=1, wr_data=0x48: commands 0x14 (delay T_NIB) then 0x18 (delay T_CMD). wr_ready is low throughout and returns high 1 cycle after the second commandDone.
- Instruction clear, rs=0, wr_data=0x01: commands 0x00 (delay T_NIB) then 0x01 (delay T_CLR). Repeat with 0x02 → T_CLR and with 0x80 → T_CMD.
- wr_valid held high in IDLE for 3 consecutive bytes: each byte is accepted only when wr_ready=1; 6 nibble transfers result, with no lost or duplicated byte.
- Spurious commandDone pulses in PWR_WAIT, IDLE and SEND_*: no state change and no extra sendCommand.
- RST asserted during WAIT_LO and during init index 5: outputs are at reset values in the same cycle; after release the full init sequence restarts from index 0 after POWERUP_CYCLES.
